enemy_control: RTL

//  Game-tick sequencer that drives the enemy subsystem's phase strobes (init, idle, gen_move, apply_move, draw).

---
 rtl/enemy_control.sv | 135 +++++++++++++
 1 files changed

// File: rtl/enemy_control.sv
// Game-tick sequencer for the enemy subsystem: INIT, then per frame IDLE -> [GEN_MOVE -> APPLY_MOVE] -> DRAW.
// Phase strobes are decoded from the registered state; a watchdog bounds the time spent waiting in DRAW.
module enemy_control #(
   parameter int CNT_W        = 20,
   parameter int INIT_CYCLES  = 4,
   parameter int FRAME_CYCLES = 833333,
   parameter int MOVE_DIV     = 4,
   parameter int DRAW_TIMEOUT = 65535
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       restart,
   input  logic       pause,
   input  logic       draw_done,
   output logic       init,
   output logic       idle,
   output logic       gen_move,
   output logic       apply_move,
   output logic       draw,
   output logic [7:0] frame_count,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      ST_INIT       = 3'd0,
      ST_IDLE       = 3'd1,
      ST_GEN_MOVE   = 3'd2,
      ST_APPLY_MOVE = 3'd3,
      ST_DRAW       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAW_LAST  = CNT_W'(DRAW_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_DIV - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
   logic [7:0]       frame_count_q, frame_count_d;
   logic             timeout_err_q, timeout_err_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_INIT;
         cyc_cnt_q     <= '0;
         move_cnt_q    <= '0;
         frame_count_q <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cyc_cnt_q     <= cyc_cnt_d;
         move_cnt_q    <= move_cnt_d;
         frame_count_q <= frame_count_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cyc_cnt_d     = cyc_cnt_q;
      move_cnt_d    = move_cnt_q;
      frame_count_d = frame_count_q;
      timeout_err_d = timeout_err_q;

      if (restart) begin
         state_d       = ST_INIT;
         cyc_cnt_d     = '0;
         move_cnt_d    = '0;
         frame_count_d = '0;
         timeout_err_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               if (cyc_cnt_q == INIT_LAST) begin
                  state_d   = ST_IDLE;
                  cyc_cnt_d = '0;
               end else begin
                  cyc_cnt_d = cyc_cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
               // Counter saturates at terminal count; pause only stalls the exit, not the count.
               if (cyc_cnt_q != FRAME_LAST) begin
                  cyc_cnt_d = cyc_cnt_q + 1'b1;
               end else if (!pause) begin
                  cyc_cnt_d = '0;
                  if (move_cnt_q == MOVE_LAST) begin
                     state_d    = ST_GEN_MOVE;
                     move_cnt_d = '0;
                  end else begin
                     state_d    = ST_DRAW;
                     move_cnt_d = move_cnt_q + 1'b1;
                  end
               end
            end
            ST_GEN_MOVE: begin
               state_d = ST_APPLY_MOVE;
            end
            ST_APPLY_MOVE: begin
               state_d   = ST_DRAW;
               cyc_cnt_d = '0;
            end
            ST_DRAW: begin
               // A completion on the watchdog's last cycle still counts as a clean draw.
               if (draw_done) begin
                  state_d       = ST_IDLE;
                  cyc_cnt_d     = '0;
                  frame_count_d = frame_count_q + 8'd1;
               end else if (cyc_cnt_q == DRAW_LAST) begin
                  state_d       = ST_IDLE;
                  cyc_cnt_d     = '0;
                  frame_count_d = frame_count_q + 8'd1;
                  timeout_err_d = 1'b1;
               end else begin
                  cyc_cnt_d = cyc_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d   = ST_INIT;
               cyc_cnt_d = '0;
            end
         endcase
      end
   end

   assign init        = (state_q == ST_INIT);
   assign idle        = (state_q == ST_IDLE);
   assign gen_move    = (state_q == ST_GEN_MOVE);
   assign apply_move  = (state_q == ST_APPLY_MOVE);
   assign draw        = (state_q == ST_DRAW);
   assign frame_count = frame_count_q;
   assign timeout_err = timeout_err_q;

endmodule
